// File: rtl/cb_agu_pkg.sv
// cb_agu_pkg
// Shared types and helpers for the CB group base-address generator.
//   state_t  : controller states, also exported on the debug state output
//   MODE_*   : storage-mode encodings for the mode input
//   res_w()  : width of the full-precision base result, before truncation to CB_AW
package cb_agu_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MUL   = 3'd1,
        ADD   = 3'd2,
        BASE  = 3'd3,
        SWEEP = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam logic MODE_TRI  = 1'b0;
    localparam logic MODE_FULL = 1'b1;

    // Wide enough to hold (n^2 + n) << tri_shift and n * row_stride without loss,
    // where n is row_len+1 bits wide.
    function automatic int res_w(input int aw, input int row_len, input int tri_shift);
        int tri_w;
        int full_w;
        tri_w  = 2 * (row_len + 1) + tri_shift;
        full_w = aw + row_len + 1;
        return (tri_w > full_w) ? tri_w : full_w;
    endfunction

endpackage

// File: rtl/cb_row_sweeper.sv
// cb_row_sweeper
// Emits ROWS consecutive row start addresses, beginning at load_addr and
// stepping by PITCH (mod 2^CB_AW) with an accumulator.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   load, load_addr   start a new sweep at load_addr
//   row_valid/ready   row output handshake
//   row_addr          current row start address
//   row_last          current row is the final one of the sweep
//   last_fire         final row accepted this cycle
//
// Handshake: a row transfers on a rising clk edge where row_valid && row_ready.
// Once row_valid is high, row_addr and row_last hold until that transfer;
// row_valid never drops without a transfer (except on reset).
module cb_row_sweeper #(
    parameter int CB_AW = 17,
    parameter int ROWS  = 4,
    parameter int PITCH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CB_AW-1:0] load_addr,
    input  logic             row_ready,
    output logic             row_valid,
    output logic [CB_AW-1:0] row_addr,
    output logic             row_last,
    output logic             last_fire
);

    localparam int CW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'((ROWS > 0) ? ROWS - 1 : 0);

    logic          active;
    logic [CW-1:0] idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active   <= 1'b0;
            idx      <= '0;
            row_addr <= '0;
        end else if (load) begin
            active   <= 1'b1;
            idx      <= '0;
            row_addr <= load_addr;
        end else if (active && row_ready) begin
            if (idx == LAST_IDX) begin
                active <= 1'b0;
            end else begin
                idx      <= idx + CW'(1);
                row_addr <= row_addr + CB_AW'(PITCH);
            end
        end
    end

    assign row_valid = active;
    assign row_last  = active && (idx == LAST_IDX);
    assign last_fire = row_valid && row_ready && row_last;

endmodule

// File: rtl/cb_group_base_agu.sv
// cb_group_base_agu
// On start, computes the base address of the next CB group
//   triangular (mode=0): ((n^2 + n) << TRI_SHIFT)
//   full-row   (mode=1): n * row_stride
// with n = group_cnt + 1, then sweeps ROWS_PER_GROUP row start addresses
// over a valid/ready handshake.
// Ports:
//   clk, sys_rst          clock, asynchronous active-high reset
//   start, mode           request pulse (accepted in IDLE only), storage mode
//   group_cnt, row_stride sampled with an accepted start
//   busy, done            request in flight / one-cycle end pulse
//   base_vld, base_addr   one-cycle pulse when base_addr updates; base held after
//   row_valid/ready/addr/last  row sweep handshake
//   ovf                   sticky overflow flag (only with CB_AGU_OVF_CHECK_EN)
//   state_dbg             current controller state
// Build option: define CB_AGU_OVF_CHECK_EN to add the ovf port and the
// dropped-bit check; otherwise results wrap silently to CB_AW bits.
module cb_group_base_agu
    import cb_agu_pkg::*;
#(
    parameter int CB_AW          = 17,
    parameter int ROW_LEN        = 10,
    parameter int TRI_SHIFT      = 1,
    parameter int ROWS_PER_GROUP = 4,
    parameter int ROW_PITCH      = 4
) (
    input  logic               clk,
    input  logic               sys_rst,
    input  logic               start,
    input  logic               mode,
    input  logic [ROW_LEN-1:0] group_cnt,
    input  logic [CB_AW-1:0]   row_stride,
    output logic               busy,
    output logic               base_vld,
    output logic [CB_AW-1:0]   base_addr,
    output logic               row_valid,
    input  logic               row_ready,
    output logic [CB_AW-1:0]   row_addr,
    output logic               row_last,
    output logic               done,
`ifdef CB_AGU_OVF_CHECK_EN
    output logic               ovf,
`endif
    output logic [2:0]         state_dbg
);

    localparam int NW = ROW_LEN + 1;
`ifdef CB_AGU_OVF_CHECK_EN
    localparam int RW = res_w(CB_AW, ROW_LEN, TRI_SHIFT);
`else
    // Multiply, add and left shift all commute with reduction mod 2^CB_AW, so
    // without the overflow check the pipeline only needs CB_AW bits.
    localparam int RW = CB_AW;
`endif

    state_t state, state_nxt;

    logic [NW-1:0]    n_q;
    logic             mode_q;
    logic [CB_AW-1:0] stride_q;
    logic [RW-1:0]    prod_q;
    logic [RW-1:0]    sum_q;
    logic [RW-1:0]    result;
    logic             last_fire;

    assign result = (mode_q == MODE_TRI) ? (sum_q << TRI_SHIFT) : sum_q;

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = MUL;
            MUL:     state_nxt = ADD;
            ADD:     state_nxt = BASE;
            BASE:    state_nxt = (ROWS_PER_GROUP > 0) ? SWEEP : DONE;
            SWEEP:   if (last_fire) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            n_q       <= '0;
            mode_q    <= MODE_TRI;
            stride_q  <= '0;
            prod_q    <= '0;
            sum_q     <= '0;
            base_addr <= '0;
            base_vld  <= 1'b0;
`ifdef CB_AGU_OVF_CHECK_EN
            ovf       <= 1'b0;
`endif
        end else begin
            // Registered alongside base_addr so both appear on the same edge.
            base_vld <= (state == BASE);
            case (state)
                IDLE: if (start) begin
                    n_q      <= {1'b0, group_cnt} + NW'(1);
                    mode_q   <= mode;
                    stride_q <= row_stride;
`ifdef CB_AGU_OVF_CHECK_EN
                    ovf      <= 1'b0;
`endif
                end
                MUL:  prod_q <= (mode_q == MODE_FULL) ? RW'(n_q) * RW'(stride_q)
                                                      : RW'(n_q) * RW'(n_q);
                ADD:  sum_q  <= (mode_q == MODE_FULL) ? prod_q : prod_q + RW'(n_q);
                BASE: begin
                    base_addr <= result[CB_AW-1:0];
`ifdef CB_AGU_OVF_CHECK_EN
                    ovf       <= ovf | (|result[RW-1:CB_AW]);
`endif
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign state_dbg = state;

    // The sweeper loads on the same edge that updates base_addr.
    cb_row_sweeper #(
        .CB_AW (CB_AW),
        .ROWS  (ROWS_PER_GROUP),
        .PITCH (ROW_PITCH)
    ) u_sweeper (
        .clk       (clk),
        .rst       (sys_rst),
        .load      ((state == BASE) && (ROWS_PER_GROUP > 0)),
        .load_addr (result[CB_AW-1:0]),
        .row_ready (row_ready),
        .row_valid (row_valid),
        .row_addr  (row_addr),
        .row_last  (row_last),
        .last_fire (last_fire)
    );

endmodule

// File: tb/tb_cb_group_base_agu.sv
module tb_cb_group_base_agu;

    localparam int CB_AW     = 17;
    localparam int ROW_LEN   = 10;
    localparam int TRI_SHIFT = 1;
    localparam int ROWS      = 4;
    localparam int PITCH     = 4;

    logic               clk;
    logic               sys_rst;
    logic               start;
    logic               mode;
    logic [ROW_LEN-1:0] group_cnt;
    logic [CB_AW-1:0]   row_stride;
    logic               busy;
    logic               base_vld;
    logic [CB_AW-1:0]   base_addr;
    logic               row_valid;
    logic               row_ready;
    logic [CB_AW-1:0]   row_addr;
    logic               row_last;
    logic               done;
`ifdef CB_AGU_OVF_CHECK_EN
    logic               ovf;
`endif
    logic [2:0]         state_dbg;

    int total = 0;
    int bad   = 0;
    logic [CB_AW-1:0] exp_q[$];

    cb_group_base_agu #(
        .CB_AW          (CB_AW),
        .ROW_LEN        (ROW_LEN),
        .TRI_SHIFT      (TRI_SHIFT),
        .ROWS_PER_GROUP (ROWS),
        .ROW_PITCH      (PITCH)
    ) dut (
        .clk        (clk),
        .sys_rst    (sys_rst),
        .start      (start),
        .mode       (mode),
        .group_cnt  (group_cnt),
        .row_stride (row_stride),
        .busy       (busy),
        .base_vld   (base_vld),
        .base_addr  (base_addr),
        .row_valid  (row_valid),
        .row_ready  (row_ready),
        .row_addr   (row_addr),
        .row_last   (row_last),
        .done       (done),
`ifdef CB_AGU_OVF_CHECK_EN
        .ovf        (ovf),
`endif
        .state_dbg  (state_dbg)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Unbounded-precision base address, straight from the storage-mode formulas.
    function automatic longint raw_base(input logic m, input int g, input longint s);
        longint n;
        n = longint'(g) + 1;
        if (m == 1'b0) return (n * n + n) << TRI_SHIFT;
        else           return n * s;
    endfunction

    // ---------------- driver: one full request ----------------
    // rmode: 0 = ready always high, 1 = ready pattern 1,0,0 repeating, 2 = random
    task automatic run_req(input logic m, input int g, input int s, input int rmode,
                           input bit poke_start);
        longint           raw;
        logic [CB_AW-1:0] b;
        int lat, hs, dones, cyc, pat;
        logic rdy;

        raw = raw_base(m, g, longint'(s));
        b   = raw[CB_AW-1:0];
        exp_q.delete();
        for (int i = 0; i < ROWS; i++) exp_q.push_back(b + CB_AW'(i * PITCH));

        @(negedge clk);
        start      = 1'b1;
        mode       = m;
        group_cnt  = ROW_LEN'(g);
        row_stride = CB_AW'(s);
        row_ready  = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1);

        lat = 1;
        while (!base_vld && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("base_latency", lat, 4);
        check("base_addr", base_addr, b);
`ifdef CB_AGU_OVF_CHECK_EN
        check("ovf_at_base", ovf, (raw >> CB_AW) != 0);
`endif

        hs = 0; dones = 0; cyc = 0; pat = 0;
        while (dones == 0 && cyc < 200) begin
            if (cyc > 0) check("no_extra_base_vld", base_vld, 0);
            if (done) begin
                dones++;
                check("rows_before_done", hs, ROWS);
            end else begin
                check("busy_in_sweep", busy, 1);
                if (row_valid) begin
                    if (exp_q.size() == 0) begin
                        check("row_extra", row_valid, 0);
                        rdy = 1'b0;
                    end else begin
                        check("row_addr", row_addr, exp_q[0]);
                        check("row_last", row_last, exp_q.size() == 1);
                        case (rmode)
                            0:       rdy = 1'b1;
                            1:       rdy = (pat % 3 == 0);
                            default: rdy = 1'($urandom_range(0, 1));
                        endcase
                        pat++;
                        if (rdy) begin
                            void'(exp_q.pop_front());
                            hs++;
                        end
                    end
                    row_ready = rdy;
                end else begin
                    row_ready = 1'b0;
                end
                // A start during the sweep must be ignored.
                start = poke_start && (cyc == 2);
                if (start) group_cnt = ROW_LEN'($urandom_range(0, 1023));
            end
            if (dones == 0) begin
                @(negedge clk);
                cyc++;
            end
        end
        if (dones == 0) check("done_timeout", 0, 1);
        check("handshakes", hs, ROWS);
        check("exp_q_empty", exp_q.size(), 0);

        // Start raised in the same cycle as done is ignored.
        row_ready = 1'b0;
        start     = 1'b1;
        group_cnt = ROW_LEN'($urandom_range(0, 1023));
        @(negedge clk);
        start = 1'b0;
        check("done_one_cycle", done, 0);
        check("start_in_done_ignored", busy, 0);
        check("idle_no_row_valid", row_valid, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("idle_no_base_vld", base_vld, 0);
        end
        check("base_addr_held", base_addr, b);
`ifdef CB_AGU_OVF_CHECK_EN
        check("ovf_sticky", ovf, (raw >> CB_AW) != 0);
`endif
    endtask

    // ---------------- reset in the middle of a sweep ----------------
    task automatic reset_mid_sweep();
        int lat;
        @(negedge clk);
        start = 1'b1; mode = 1'b0; group_cnt = ROW_LEN'(5); row_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!base_vld && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("rst_base_latency", lat, 4);
        row_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        row_ready = 1'b0;
        check("rst_pre_valid", row_valid, 1);
        check("rst_pre_row", row_addr, CB_AW'(((6 * 6 + 6) << TRI_SHIFT) + 2 * PITCH));
        #2 sys_rst = 1'b1;
        #1;
        check("rst_busy", busy, 0);
        check("rst_base_vld", base_vld, 0);
        check("rst_base_addr", base_addr, 0);
        check("rst_row_valid", row_valid, 0);
        check("rst_row_addr", row_addr, 0);
        check("rst_row_last", row_last, 0);
        check("rst_done", done, 0);
        check("rst_state", state_dbg, 0);
        @(negedge clk);
        check("rst_hold_done", done, 0);
        sys_rst = 1'b0;
        @(negedge clk);
        check("post_rst_done", done, 0);
        check("post_rst_busy", busy, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        sys_rst    = 1'b1;
        start      = 1'b0;
        mode       = 1'b0;
        group_cnt  = '0;
        row_stride = '0;
        row_ready  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_base_vld", base_vld, 0);
        check("reset_base_addr", base_addr, 0);
        check("reset_row_valid", row_valid, 0);
        check("reset_row_addr", row_addr, 0);
        check("reset_row_last", row_last, 0);
        check("reset_done", done, 0);
        check("reset_state", state_dbg, 0);
`ifdef CB_AGU_OVF_CHECK_EN
        check("reset_ovf", ovf, 0);
`endif
        sys_rst = 1'b0;
        @(negedge clk);

        run_req(1'b0, 0, 0, 0, 1'b0);        // base 4
        run_req(1'b0, 3, 0, 0, 1'b0);        // base 40
        run_req(1'b1, 2, 20, 0, 1'b0);       // base 60
        run_req(1'b0, 7, 0, 1, 1'b1);        // stalled ready, start poked mid-sweep
        reset_mid_sweep();
        run_req(1'b0, 0, 0, 0, 1'b0);        // fresh start after reset, base 4
        run_req(1'b0, 1023, 0, 2, 1'b0);     // largest n, result wraps
        run_req(1'b0, 0, 0, 0, 1'b0);        // clears any overflow flag
        run_req(1'b1, 0, 131068, 0, 1'b0);   // rows wrap past 2^CB_AW
        run_req(1'b1, 1023, 131071, 2, 1'b1);

        for (int i = 0; i < 10; i++) begin
            run_req(1'($urandom_range(0, 1)), int'($urandom_range(0, 1023)),
                    int'($urandom_range(0, (1 << CB_AW) - 1)),
                    int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
